sd_sector_sched: RTL and testbench

//   Sequencer/arbiter sharing the single SD-card sector port between floppy drives 0/1 and ACSI targets 0/1.

---
 rtl/sd_sector_sched_if.sv | 36 +++
 rtl/sd_sector_sched.sv | 153 +++++++++++++++
 tb/tb_sd_sector_sched.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_sched_if.sv
// sd_sector_sched_if: request/strobe bundle between floppy, ACSI, DMA and SD sides of the sector scheduler.
interface sd_sector_sched_if;
  logic [1:0]  fdc_rd_req;
  logic [1:0]  fdc_wr_req;
  logic [31:0] fdc_lba;
  logic        fdc_busy;
  logic        fdc_done;
  logic [1:0]  acsi_rd_req;
  logic [1:0]  acsi_wr_req;
  logic [31:0] acsi_lba;
  logic [15:0] acsi_length;
  logic        acsi_busy;
  logic        acsi_done;
  logic        acsi_next;
  logic        acsi_dma_done;
  logic        dma_sector_ack;
  logic [3:0]  sd_rd;
  logic [3:0]  sd_wr;
  logic [31:0] sd_lba;
  logic        sd_busy;
  logic        sd_done;
  logic        sd_error;
  logic        error;
  modport master (
    output fdc_rd_req, fdc_wr_req, fdc_lba, acsi_rd_req, acsi_wr_req, acsi_lba, acsi_length,
           dma_sector_ack, sd_busy, sd_done, sd_error,
    input  fdc_busy, fdc_done, acsi_busy, acsi_done, acsi_next, acsi_dma_done, sd_rd, sd_wr,
           sd_lba, error
  );
  modport slave (
    input  fdc_rd_req, fdc_wr_req, fdc_lba, acsi_rd_req, acsi_wr_req, acsi_lba, acsi_length,
           dma_sector_ack, sd_busy, sd_done, sd_error,
    output fdc_busy, fdc_done, acsi_busy, acsi_done, acsi_next, acsi_dma_done, sd_rd, sd_wr,
           sd_lba, error
  );
endinterface

// File: rtl/sd_sector_sched.sv
// sd_sector_sched: arbitrates the single SD sector port between floppy drives 0/1 and ACSI targets 0/1,
// sequences multi-sector ACSI transfers against DMA acks and aborts hung transactions via a watchdog.
module sd_sector_sched #(
  parameter logic [23:0] TIMEOUT   = 24'd8_000_000,
  parameter bit          FDC_FIRST = 1'b1
) (
  input logic             clk,
  input logic             reset,
  sd_sector_sched_if.slave io_bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, WAIT_DMA} state_t;
  state_t      r_state, w_state_nxt;
  logic        r_acsi, r_last_fdc, r_active;
  logic [15:0] r_remaining;
  logic [23:0] r_wdog;
  logic [3:0]  r_sd_rd, r_sd_wr;
  logic [31:0] r_sd_lba;
  logic        r_fdc_busy, r_fdc_done, r_acsi_busy, r_acsi_done, r_acsi_next, r_acsi_dma_done, r_error;
  logic [1:0]  w_fdc_req, w_acsi_req, w_cls_req, w_cls_rd;
  logic        w_fdc_pend, w_acsi_pend, w_pick_fdc, w_idx, w_rd, w_to;
  logic [3:0]  w_onehot;
  logic [31:0] w_grant_lba;
  logic [15:0] w_len;
  logic        w_grant, w_abort, w_dec, w_finish;
  logic        w_fdc_busy, w_fdc_done, w_acsi_busy, w_acsi_done, w_acsi_next, w_error;
  // A class is masked while its busy strobe is out so a still-held request is not granted twice
  assign w_fdc_req   = (io_bus.fdc_rd_req | io_bus.fdc_wr_req) & {2{~r_fdc_busy}};
  assign w_acsi_req  = (io_bus.acsi_rd_req | io_bus.acsi_wr_req) & {2{~r_acsi_busy}};
  assign w_fdc_pend  = |w_fdc_req;
  assign w_acsi_pend = |w_acsi_req;
  assign w_pick_fdc  = w_fdc_pend & (~w_acsi_pend | ~r_last_fdc);
  assign w_cls_req   = w_pick_fdc ? w_fdc_req : w_acsi_req;
  assign w_cls_rd    = w_pick_fdc ? io_bus.fdc_rd_req : io_bus.acsi_rd_req;
  assign w_idx       = w_cls_req == 2'b10;
  assign w_rd        = w_cls_rd[w_idx];
  assign w_onehot    = 4'b0001 << {~w_pick_fdc, w_idx};
  assign w_grant_lba = w_pick_fdc ? io_bus.fdc_lba : io_bus.acsi_lba;
  assign w_len       = io_bus.acsi_length == 16'd0 ? 16'd1 : io_bus.acsi_length;
  assign w_to        = r_state != IDLE && r_wdog == TIMEOUT - 24'd1;
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_abort     = 1'b0;
    w_dec       = 1'b0;
    w_finish    = 1'b0;
    w_fdc_busy  = 1'b0;
    w_fdc_done  = 1'b0;
    w_acsi_busy = 1'b0;
    w_acsi_done = 1'b0;
    w_acsi_next = 1'b0;
    w_error     = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant     = w_fdc_pend | w_acsi_pend;
        w_state_nxt = w_grant ? ISSUE : IDLE;
      end
      ISSUE, WAIT_DONE: begin
        if (w_to) begin
          w_error     = 1'b1;
          w_abort     = r_acsi;
          w_state_nxt = IDLE;
        end else if (io_bus.sd_error) begin
          w_error     = 1'b1;
          w_fdc_done  = ~r_acsi;
          w_acsi_done = r_acsi;
          w_abort     = r_acsi;
          w_state_nxt = IDLE;
        end else begin
          if (r_state == ISSUE && io_bus.sd_busy) begin
            w_fdc_busy  = ~r_acsi;
            w_acsi_busy = r_acsi;
            w_state_nxt = WAIT_DONE;
          end
          if ((r_state == WAIT_DONE || io_bus.sd_busy) && io_bus.sd_done) begin
            w_fdc_done  = ~r_acsi;
            w_acsi_done = r_acsi;
            w_dec       = r_acsi;
            w_state_nxt = r_acsi ? WAIT_DMA : IDLE;
          end
        end
      end
      WAIT_DMA: begin
        if (w_to) begin
          w_error     = 1'b1;
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if (io_bus.dma_sector_ack) begin
          w_acsi_next = r_remaining != 16'd0;
          w_finish    = r_remaining == 16'd0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acsi          <= 1'b0;
      r_last_fdc      <= ~FDC_FIRST;
      r_active        <= 1'b0;
      r_remaining     <= 16'd0;
      r_wdog          <= 24'd0;
      r_sd_rd         <= 4'd0;
      r_sd_wr         <= 4'd0;
      r_sd_lba        <= 32'd0;
      r_fdc_busy      <= 1'b0;
      r_fdc_done      <= 1'b0;
      r_acsi_busy     <= 1'b0;
      r_acsi_done     <= 1'b0;
      r_acsi_next     <= 1'b0;
      r_acsi_dma_done <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_sd_rd <= w_grant ? (w_rd ? w_onehot : 4'd0) : (w_state_nxt == ISSUE ? r_sd_rd : 4'd0);
      r_sd_wr <= w_grant ? (w_rd ? 4'd0 : w_onehot) : (w_state_nxt == ISSUE ? r_sd_wr : 4'd0);
      if (w_grant) begin
        r_acsi     <= ~w_pick_fdc;
        r_last_fdc <= w_pick_fdc;
        r_sd_lba   <= w_grant_lba;
      end
      r_active <= (w_abort | w_finish) ? 1'b0 : (w_grant & ~w_pick_fdc) ? 1'b1 : r_active;
      // Length is sampled only on the first sector of a transfer
      if (w_abort)
        r_remaining <= 16'd0;
      else if (w_grant && !w_pick_fdc && !r_active)
        r_remaining <= w_len;
      else if (w_dec && r_remaining != 16'd0)
        r_remaining <= r_remaining - 16'd1;
      r_wdog          <= (r_state == IDLE || w_state_nxt != r_state) ? 24'd0 : r_wdog + 24'd1;
      r_fdc_busy      <= w_fdc_busy;
      r_fdc_done      <= w_fdc_done;
      r_acsi_busy     <= w_acsi_busy;
      r_acsi_done     <= w_acsi_done;
      r_acsi_next     <= w_acsi_next;
      r_acsi_dma_done <= w_abort | w_finish;
      r_error         <= w_error;
    end
  end
  assign io_bus.sd_rd         = r_sd_rd;
  assign io_bus.sd_wr         = r_sd_wr;
  assign io_bus.sd_lba        = r_sd_lba;
  assign io_bus.fdc_busy      = r_fdc_busy;
  assign io_bus.fdc_done      = r_fdc_done;
  assign io_bus.acsi_busy     = r_acsi_busy;
  assign io_bus.acsi_done     = r_acsi_done;
  assign io_bus.acsi_next     = r_acsi_next;
  assign io_bus.acsi_dma_done = r_acsi_dma_done;
  assign io_bus.error         = r_error;
endmodule

// File: tb/tb_sd_sector_sched.sv
// tb_sd_sector_sched: table-driven single-sector vectors plus hand sequences, checked through an event scoreboard.
module tb_sd_sector_sched;
  localparam logic [6:0] FB = 7'd1, FD = 7'd2, AB = 7'd4, AD = 7'd8, AN = 7'd16, ADD = 7'd32, ER = 7'd64;
  typedef struct packed {
    logic [6:0]  strb;
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [31:0] lba;
  } ev_t;
  typedef struct {
    bit          acsi;
    bit          wr;
    int          idx;
    logic [31:0] lba;
    logic [15:0] len;
    int          bdly;
    int          ddly;
    logic [3:0]  exp_rd;
    logic [3:0]  exp_wr;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  ev_t  exp_q[$];
  logic [3:0] prev_g = 4'd0;
  sd_sector_sched_if bus();
  sd_sector_sched #(.TIMEOUT(24'd16), .FDC_FIRST(1'b1)) dut (.clk(clk), .reset(reset), .io_bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  task automatic push_grant(input logic [3:0] rd, input logic [3:0] wr, input logic [31:0] lba);
    ev_t e;
    e.strb = 7'd0;
    e.rd   = rd;
    e.wr   = wr;
    e.lba  = lba;
    exp_q.push_back(e);
  endtask
  task automatic push_strb(input logic [6:0] s);
    ev_t e;
    e.strb = s;
    e.rd   = 4'd0;
    e.wr   = 4'd0;
    e.lba  = 32'd0;
    exp_q.push_back(e);
  endtask
  task automatic see(input ev_t a);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event got strb=%b rd=%b wr=%b lba=%h", a.strb, a.rd, a.wr, a.lba);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        bad++;
        $display("FAIL event got strb=%b rd=%b wr=%b lba=%h want strb=%b rd=%b wr=%b lba=%h",
                 a.strb, a.rd, a.wr, a.lba, e.strb, e.rd, e.wr, e.lba);
      end
    end
  endtask
  always @(negedge clk) begin
    ev_t a;
    logic [3:0] g;
    g = bus.sd_rd | bus.sd_wr;
    if (g != 4'd0 && prev_g == 4'd0) begin
      a.strb = 7'd0;
      a.rd   = bus.sd_rd;
      a.wr   = bus.sd_wr;
      a.lba  = bus.sd_lba;
      see(a);
    end
    a.strb = {bus.error, bus.acsi_dma_done, bus.acsi_next, bus.acsi_done, bus.acsi_busy, bus.fdc_done, bus.fdc_busy};
    if (a.strb != 7'd0) begin
      a.rd  = 4'd0;
      a.wr  = 4'd0;
      a.lba = 32'd0;
      see(a);
    end
    prev_g = g;
  end
  task automatic wait_grant(output bit ok);
    int n = 0;
    while ((bus.sd_rd | bus.sd_wr) == 4'd0 && n < 40) begin
      tick();
      n++;
    end
    ok = (bus.sd_rd | bus.sd_wr) != 4'd0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL grant_timeout got=none want=grant");
    end
  endtask
  task automatic serve(input int bdly, input int ddly, input int edly);
    bit ok;
    logic [3:0] gr, gw;
    int lim;
    wait_grant(ok);
    if (!ok) return;
    gr  = bus.sd_rd;
    gw  = bus.sd_wr;
    lim = (edly >= 0 ? edly : ddly) + 1;
    for (int k = 0; k <= lim; k++) begin
      if (k == bdly + 1) begin
        bus.fdc_rd_req  = bus.fdc_rd_req & ~gr[1:0];
        bus.fdc_wr_req  = bus.fdc_wr_req & ~gw[1:0];
        bus.acsi_rd_req = bus.acsi_rd_req & ~gr[3:2];
        bus.acsi_wr_req = bus.acsi_wr_req & ~gw[3:2];
      end
      bus.sd_busy  = k == bdly;
      bus.sd_done  = k == ddly || k == edly;
      bus.sd_error = k == edly;
      tick();
    end
    bus.sd_busy  = 1'b0;
    bus.sd_done  = 1'b0;
    bus.sd_error = 1'b0;
  endtask
  task automatic ack();
    bus.dma_sector_ack = 1'b1;
    tick();
    bus.dma_sector_ack = 1'b0;
    tick();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench did not terminate");
  end
  initial begin
    vec_t tbl[7];
    bit ok;
    tbl[0] = '{0, 0, 0, 32'd5,          16'd0, 3, 10, 4'b0001, 4'b0000};
    tbl[1] = '{0, 1, 1, 32'h0000_1234,  16'd0, 1, 4,  4'b0000, 4'b0010};
    tbl[2] = '{1, 0, 0, 32'd100,        16'd0, 2, 5,  4'b0100, 4'b0000};
    tbl[3] = '{1, 1, 1, 32'hdead_beef,  16'd1, 0, 0,  4'b0000, 4'b1000};
    tbl[4] = '{0, 0, 1, 32'd7,          16'd0, 2, 2,  4'b0010, 4'b0000};
    tbl[5] = '{1, 0, 1, 32'd42,         16'd1, 1, 3,  4'b1000, 4'b0000};
    tbl[6] = '{0, 1, 0, 32'hffff_ffff,  16'd0, 0, 6,  4'b0000, 4'b0001};
    bus.fdc_rd_req = 2'b00; bus.fdc_wr_req = 2'b00; bus.fdc_lba = 32'd0;
    bus.acsi_rd_req = 2'b00; bus.acsi_wr_req = 2'b00; bus.acsi_lba = 32'd0; bus.acsi_length = 16'd0;
    bus.dma_sector_ack = 1'b0; bus.sd_busy = 1'b0; bus.sd_done = 1'b0; bus.sd_error = 1'b0;
    do_reset();
    chk("rst_sd_rd", 64'(bus.sd_rd), 64'd0);
    chk("rst_sd_wr", 64'(bus.sd_wr), 64'd0);
    chk("rst_sd_lba", 64'(bus.sd_lba), 64'd0);
    chk("rst_strobes", 64'({bus.error, bus.acsi_dma_done, bus.acsi_next, bus.acsi_done, bus.acsi_busy,
                            bus.fdc_done, bus.fdc_busy}), 64'd0);
    for (int i = 0; i < 7; i++) begin
      logic [6:0] bsy, dn;
      bsy = tbl[i].acsi ? AB : FB;
      dn  = tbl[i].acsi ? AD : FD;
      if (tbl[i].acsi) begin
        bus.acsi_lba = tbl[i].lba;
        bus.acsi_length = tbl[i].len;
        if (tbl[i].wr) bus.acsi_wr_req[tbl[i].idx] = 1'b1;
        else           bus.acsi_rd_req[tbl[i].idx] = 1'b1;
      end else begin
        bus.fdc_lba = tbl[i].lba;
        if (tbl[i].wr) bus.fdc_wr_req[tbl[i].idx] = 1'b1;
        else           bus.fdc_rd_req[tbl[i].idx] = 1'b1;
      end
      push_grant(tbl[i].exp_rd, tbl[i].exp_wr, tbl[i].lba);
      if (tbl[i].bdly == tbl[i].ddly) push_strb(bsy | dn);
      else begin
        push_strb(bsy);
        push_strb(dn);
      end
      if (tbl[i].acsi) push_strb(ADD);
      serve(tbl[i].bdly, tbl[i].ddly, -1);
      if (tbl[i].acsi) ack();
      repeat (2) tick();
    end
    // read beats write on one drive, lower drive index first
    bus.fdc_lba = 32'd50; bus.fdc_rd_req = 2'b11; bus.fdc_wr_req = 2'b01;
    push_grant(4'b0001, 4'b0000, 32'd50); push_strb(FB); push_strb(FD);
    push_grant(4'b0000, 4'b0001, 32'd50); push_strb(FB); push_strb(FD);
    push_grant(4'b0010, 4'b0000, 32'd50); push_strb(FB); push_strb(FD);
    repeat (3) serve(0, 1, -1);
    repeat (2) tick();
    // alternation straight after reset: floppy preferred first
    do_reset();
    bus.fdc_lba = 32'd11; bus.acsi_lba = 32'd22; bus.acsi_length = 16'd1;
    bus.fdc_rd_req = 2'b10; bus.acsi_wr_req = 2'b10;
    push_grant(4'b0010, 4'b0000, 32'd11); push_strb(FB); push_strb(FD);
    push_grant(4'b0000, 4'b1000, 32'd22); push_strb(AB); push_strb(AD); push_strb(ADD);
    serve(1, 3, -1);
    serve(2, 4, -1);
    ack();
    repeat (2) tick();
    // three-sector ACSI read; length change mid-transfer must be ignored
    bus.acsi_length = 16'd3;
    for (int s = 0; s < 3; s++) begin
      bus.acsi_lba = 32'd1000 + 32'(s);
      bus.acsi_rd_req = 2'b01;
      push_grant(4'b0100, 4'b0000, 32'd1000 + 32'(s));
      push_strb(AB); push_strb(AD); push_strb(s < 2 ? AN : ADD);
      serve(1, 4, -1);
      if (s == 0) bus.acsi_length = 16'd0;
      ack();
    end
    repeat (2) tick();
    // error on the second of four sectors aborts the whole transfer
    bus.acsi_length = 16'd4; bus.acsi_lba = 32'd2000; bus.acsi_wr_req = 2'b10;
    push_grant(4'b0000, 4'b1000, 32'd2000); push_strb(AB); push_strb(AD); push_strb(AN);
    serve(0, 2, -1);
    ack();
    bus.acsi_lba = 32'd2001; bus.acsi_wr_req = 2'b10;
    push_grant(4'b0000, 4'b1000, 32'd2001); push_strb(AB); push_strb(ER | AD | ADD);
    serve(1, 3, 3);
    repeat (2) tick();
    // fresh transfer must resample length (2 sectors -> one acsi_next)
    bus.acsi_length = 16'd2; bus.acsi_lba = 32'd3000; bus.acsi_rd_req = 2'b01;
    push_grant(4'b0100, 4'b0000, 32'd3000); push_strb(AB); push_strb(AD); push_strb(AN);
    serve(1, 2, -1);
    ack();
    bus.acsi_lba = 32'd3001; bus.acsi_rd_req = 2'b01;
    push_grant(4'b0100, 4'b0000, 32'd3001); push_strb(AB); push_strb(AD); push_strb(ADD);
    serve(1, 2, -1);
    ack();
    repeat (2) tick();
    // watchdog: sd_busy never comes
    bus.fdc_lba = 32'd9; bus.fdc_rd_req = 2'b01;
    push_grant(4'b0001, 4'b0000, 32'd9); push_strb(ER);
    wait_grant(ok);
    repeat (15) tick();
    chk("to_hold_sd_rd", 64'(bus.sd_rd), 64'd1);
    chk("to_hold_err", 64'(bus.error), 64'd0);
    tick();
    chk("to_drop_sd_rd", 64'(bus.sd_rd), 64'd0);
    chk("to_err", 64'(bus.error), 64'd1);
    bus.fdc_rd_req = 2'b00;
    repeat (3) tick();
    // reset during ISSUE drops sd_rd
    bus.fdc_lba = 32'd77; bus.fdc_rd_req = 2'b01;
    push_grant(4'b0001, 4'b0000, 32'd77);
    wait_grant(ok);
    chk("rst_pre_sd_rd", 64'(bus.sd_rd), 64'd1);
    reset = 1'b1; bus.fdc_rd_req = 2'b00;
    tick();
    chk("rst_issue_sd_rd", 64'(bus.sd_rd), 64'd0);
    reset = 1'b0;
    repeat (2) tick();
    // reset during WAIT_DONE, coinciding with sd_done, emits no strobe
    bus.fdc_lba = 32'd78; bus.fdc_rd_req = 2'b01;
    push_grant(4'b0001, 4'b0000, 32'd78); push_strb(FB);
    wait_grant(ok);
    bus.sd_busy = 1'b1;
    tick();
    bus.sd_busy = 1'b0; bus.fdc_rd_req = 2'b00;
    tick();
    reset = 1'b1; bus.sd_done = 1'b1;
    tick();
    chk("rst_wd_outputs", 64'({bus.sd_rd, bus.sd_wr, bus.error, bus.acsi_dma_done, bus.acsi_next,
                               bus.acsi_done, bus.acsi_busy, bus.fdc_done, bus.fdc_busy}), 64'd0);
    chk("rst_wd_lba", 64'(bus.sd_lba), 64'd0);
    reset = 1'b0; bus.sd_done = 1'b0;
    repeat (4) tick();
    chk("leftover_events", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
